// File: rtl/lsu_rmw.sv
// Purpose: MEM-stage load/store unit in front of a word-only data memory; sub-word stores become read-modify-write.
// Latency: loads and sw take 0 extra cycles; sb/sh read in cycle 1 and write the merged word in cycle 2.
// Backpressure: stall is raised for exactly one cycle while an sb/sh reads the old word; no other stall source.
module lsu_rmw #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        fault,
  output logic        dm_we,
  output logic [31:0] dm_a,
  output logic [31:0] dm_wd,
  input  logic [31:0] dm_rd
);

  typedef enum logic {IDLE, MERGE} state_t;

  localparam logic [29:0] WORDS = 30'(MEM_WORDS);

  state_t      state;
  logic [31:0] s_addr;
  logic [31:0] s_word;

  logic        ld_ok, st_ok, acc, sz_h, sz_w, misal, oor, go;
  logic        ld_go, sw_go, sub_st;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] merged;

  // Request decode: a conflicting read+write or an unsupported funct3 is treated as no access.
  always_comb begin
    ld_ok  = mem_read && !mem_write && (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    st_ok  = mem_write && !mem_read && (funct3 inside {3'b000, 3'b001, 3'b010});
    acc    = (ld_ok || st_ok) && (state == IDLE) && !reset;
    sz_h   = (funct3[1:0] == 2'b01);
    sz_w   = (funct3[1:0] == 2'b10);
    misal  = (sz_w && (addr[1:0] != 2'b00)) || (sz_h && addr[0]);
    oor    = (addr[31:2] >= WORDS);
    fault  = acc && (misal || oor);
    go     = acc && !fault;
    ld_go  = go && ld_ok;
    sw_go  = go && st_ok && sz_w;
    sub_st = go && st_ok && !sz_w;
  end

  // Load lane extraction and sign/zero extension; zero unless a valid load is being serviced.
  always_comb begin
    ld_byte = dm_rd[{addr[1:0], 3'b000} +: 8];
    ld_half = addr[1] ? dm_rd[31:16] : dm_rd[15:0];
    case (funct3)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = dm_rd;
    endcase
    rdata = ld_go ? ld_ext : 32'h0;
  end

  // Old word with the addressed byte/half lane replaced by the store data.
  always_comb begin
    merged = dm_rd;
    if (sz_h) merged[{addr[1], 4'b0000} +: 16] = wdata[15:0];
    else      merged[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
  end

  // Memory port: MERGE replays the saved address/word, otherwise the live request drives it.
  always_comb begin
    stall = sub_st;
    dm_we = !reset && ((state == MERGE) || sw_go);
    dm_a  = (state == MERGE) ? s_addr : addr;
    dm_wd = (state == MERGE) ? s_word : wdata;
  end

  // RMW sequencer: capture the merged word on the read cycle, write it back on the next.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      s_addr <= 32'h0;
      s_word <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (sub_st) begin
            s_addr <= addr;
            s_word <= merged;
            state  <= MERGE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_rmw.sv
// Purpose: scoreboard bench for lsu_rmw with a behavioural word memory behind the dm_* port.
// Latency: expectations are queued when stimulus is applied and popped by a negedge monitor.
// Backpressure: the driver holds a stalled sb/sh for its MERGE cycle, as the frozen pipeline would.
module tb_lsu_rmw;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        stall;
  logic        fault;
  logic        dm_we;
  logic [31:0] dm_a;
  logic [31:0] dm_wd;
  logic [31:0] dm_rd;

  typedef struct packed {
    logic stall;
    logic fault;
    logic we;
  } cyc_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  cyc_t        cyc_q[$];
  wr_t         wr_q[$];
  logic [31:0] ld_q[$];

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [0:63];
  logic        mem_init = 1'b0;

  lsu_rmw #(.MEM_WORDS(64)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
    .stall(stall), .fault(fault), .dm_we(dm_we), .dm_a(dm_a),
    .dm_wd(dm_wd), .dm_rd(dm_rd)
  );

  always #5 clk = ~clk;

  // Behavioural word memory: combinational read, write on the clock edge, preloaded on the first edge.
  assign dm_rd = (dm_a[31:2] < 30'd64) ? mem[dm_a[7:2]] : 32'h0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[4]   <= 32'h8899AABB;
      mem_init <= 1'b1;
    end else if (dm_we && (dm_a[31:2] < 30'd64)) begin
      mem[dm_a[7:2]] <= dm_wd;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: per-cycle control flags, every write presented, every serviced load.
  always @(negedge clk) begin
    cyc_t e;
    wr_t  w;
    if (cyc_q.size() > 0) begin
      e = cyc_q.pop_front();
      chk("stall", {31'h0, stall}, {31'h0, e.stall});
      chk("fault", {31'h0, fault}, {31'h0, e.fault});
      chk("dm_we", {31'h0, dm_we}, {31'h0, e.we});
    end
    if (dm_we) begin
      if (wr_q.size() == 0) begin
        chk("unexpected_write", dm_a, 32'hFFFFFFFF);
      end else begin
        w = wr_q.pop_front();
        chk("dm_a", dm_a, w.a);
        chk("dm_wd", dm_wd, w.d);
      end
    end
    if (mem_read && !mem_write && !stall && !reset) begin
      if (ld_q.size() == 0) chk("unexpected_load", rdata, 32'hFFFFFFFF);
      else chk("rdata", rdata, ld_q.pop_front());
    end
  end

  task automatic drv(input logic rs, input logic mr, input logic mw, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic es, input logic ef, input logic ew);
    reset     = rs;
    mem_read  = mr;
    mem_write = mw;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    cyc_q.push_back('{stall: es, fault: ef, we: ew});
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp, input logic ef);
    ld_q.push_back(exp);
    drv(1'b0, 1'b1, 1'b0, f3, a, 32'h0, 1'b0, ef, 1'b0);
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] wd);
    wr_q.push_back('{a: a, d: wd});
    drv(1'b0, 1'b0, 1'b1, 3'b010, a, wd, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic st_sub(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] merged);
    drv(1'b0, 1'b0, 1'b1, f3, a, wd, 1'b1, 1'b0, 1'b0);
    wr_q.push_back('{a: a, d: merged});
    drv(1'b0, 1'b0, 1'b1, f3, a, wd, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    // Reset holds outputs low even with a misaligned store presented.
    drv(1'b1, 1'b0, 1'b1, 3'b010, 32'h11, 32'h1, 1'b0, 1'b0, 1'b0);
    drv(1'b1, 1'b0, 1'b1, 3'b000, 32'h11, 32'h1, 1'b0, 1'b0, 1'b0);

    // Loads from preloaded word 0x10 = 0x8899AABB.
    ld(3'b000, 32'h10, 32'hFFFFFFBB, 1'b0);
    ld(3'b100, 32'h10, 32'h000000BB, 1'b0);
    ld(3'b001, 32'h12, 32'hFFFF8899, 1'b0);
    ld(3'b101, 32'h12, 32'h00008899, 1'b0);
    ld(3'b010, 32'h10, 32'h8899AABB, 1'b0);
    ld(3'b000, 32'h13, 32'hFFFFFF88, 1'b0);
    ld(3'b100, 32'h12, 32'h00000099, 1'b0);
    ld(3'b001, 32'h10, 32'hFFFFAABB, 1'b0);

    // Sub-word read-modify-write stores.
    st_sub(3'b000, 32'h11, 32'h000000CC, 32'h8899CCBB);
    st_sub(3'b001, 32'h12, 32'h00001234, 32'h1234CCBB);
    chk("mem_10_after_rmw", mem[4], 32'h1234CCBB);

    // Full-word store and read-back.
    sw(32'h20, 32'hDEADBEEF);
    ld(3'b010, 32'h20, 32'hDEADBEEF, 1'b0);

    // Faulting accesses: no write, no stall, zero data.
    drv(1'b0, 1'b0, 1'b1, 3'b010, 32'h11, 32'h12345678, 1'b0, 1'b1, 1'b0);
    ld(3'b001, 32'h13, 32'h0, 1'b1);
    ld(3'b010, 32'h100, 32'h0, 1'b1);
    drv(1'b0, 1'b0, 1'b1, 3'b000, 32'h100, 32'h77, 1'b0, 1'b1, 1'b0);
    chk("mem_10_after_faults", mem[4], 32'h1234CCBB);

    // Unsupported funct3: no access and no fault even when misaligned.
    drv(1'b0, 1'b0, 1'b1, 3'b100, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
    drv(1'b0, 1'b0, 1'b1, 3'b011, 32'h11, 32'h0, 1'b0, 1'b0, 1'b0);
    ld(3'b011, 32'h10, 32'h0, 1'b0);
    ld(3'b110, 32'h13, 32'h0, 1'b0);
    drv(1'b0, 1'b1, 1'b1, 3'b010, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0);

    // Reset during MERGE suppresses the write and returns to IDLE.
    sw(32'h10, 32'h8899AABB);
    drv(1'b0, 1'b0, 1'b1, 3'b000, 32'h10, 32'h55, 1'b1, 1'b0, 1'b0);
    drv(1'b1, 1'b0, 1'b1, 3'b000, 32'h10, 32'h55, 1'b0, 1'b0, 1'b0);
    drv(1'b0, 1'b0, 1'b0, 3'b000, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("mem_10_after_reset_merge", mem[4], 32'h8899AABB);
    ld(3'b010, 32'h10, 32'h8899AABB, 1'b0);

    // Back-to-back sb then lw on the same word.
    st_sub(3'b000, 32'h14, 32'h00000055, 32'h00000055);
    ld(3'b010, 32'h14, 32'h00000055, 1'b0);

    // Drain and confirm every expectation was consumed.
    drv(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    drv(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    chk("cyc_q_left", cyc_q.size(), 32'h0);
    chk("wr_q_left", wr_q.size(), 32'h0);
    chk("ld_q_left", ld_q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
